usb_gpx_event_ctrl: RTL and testbench
=====================================

Name: usb_gpx_event_ctrl

Overview:
- Conditions the USB controller's GPX/interrupt pin and turns it into a software-visible event source for the Nios II.
- Sync chain, glitch filter FSM, edge-capture register (write-1-to-clear), per-edge interrupt mask and saturating rising-edge counter.
- Sits on the Avalon-MM bus as a 4-word slave.
- Drives a level irq to the CPU interrupt controller.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops (legal range 2..4).
- FILTER_CYCLES, 4, consecutive synced cycles the input must hold a new level before the filtered level changes (legal range 1..255).
- CNT_W, 16, width of the rising-edge event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  1  raw GPX pin, asynchronous to clk.
- irq  out  1  level interrupt request.

Behaviour:
- Reset: all sync flops 0, FSM in STABLE_LO, filter counter 0, filtered level 0, mask 0, edgecapture 0, event count 0, readdata 0, irq 0.
- Synchronizer: in_port passes through SYNC_STAGES flops to give sync_in.
- Filter FSM states:
  - STABLE_LO: stay while sync_in=0; go to PEND_HI with counter=1 when sync_in=1.
  - PEND_HI: if sync_in=0, return to STABLE_LO and clear counter. If sync_in=1 and counter=FILTER_CYCLES, go to STABLE_HI, set filtered=1 and pulse rise for 1 cycle. Otherwise increment counter.
  - STABLE_HI and PEND_LO: mirror image; completion pulses fall.
  - FILTER_CYCLES=1: the first differing sync_in sample completes the pend immediately.
- Latency: filtered level and rise/fall pulse appear SYNC_STAGES+FILTER_CYCLES clk edges after the first edge that samples the new in_port level.
- Register map (readdata updated every clk from the current address; 1-cycle read latency; unused bits read 0):
  - 0 STATUS (RO): bit0 filtered level, bit1 sync_in.
  - 1 IRQMASK (RW): bit0 rise enable, bit1 fall enable. Writes take effect at the next edge.
  - 2 EDGECAP (RW1C): bit0 rise seen, bit1 fall seen. Bits are set by the rise/fall pulses and cleared by writing 1. A set and a clear in the same cycle on the same bit: set wins, bit stays 1.
  - 3 EVCOUNT (RO data, write-any-clears): bits [CNT_W-1:0] count rise pulses and saturate at all-ones. A clear and a rise in the same cycle give count=1.
- Write only when chipselect=1 and write_n=0. Writes to address 0 are ignored.
- irq = OR over (EDGECAP & IRQMASK), decoded from registers with no extra flop. It falls the cycle after the clearing write edge.
- Reset mid-operation: everything returns to reset values and any pending filter state is discarded. If in_port is 1 at reset release, a rise is detected after the normal latency (intended: software sees the pin as asserted).

Decomposition:
- Package usb_gpx_pkg:
  - register address constants STATUS/IRQMASK/EDGECAP/EVCOUNT.
  - bit indices RISE_BIT=0, FALL_BIT=1.
  - FSM state enum {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO}.
- Sub-module usb_gpx_filter:
  - contains the synchronizer and filter FSM.
  - outputs sync_in, filtered, rise and fall.
  - the top level holds the registers, counter, read mux and irq.

Test Plan:
- Reset, then read all four addresses -> readdata=0 each; irq=0.
- Defaults; drive in_port 0->1 and hold -> STATUS reads 0x3 after 6 clks; EDGECAP reads 0x1; EVCOUNT reads 1; irq stays 0 (mask 0).
- Write IRQMASK=0x1; pulse in_port high for 3 clks (< FILTER_CYCLES) -> no EDGECAP change and irq=0. Then hold high 10 clks -> irq=1. Write EDGECAP=0x1 -> irq=0 the next cycle.
- Write EDGECAP=0x1 on the same edge that a rise pulse fires -> EDGECAP bit0 remains 1.
- CNT_W=4: generate 20 filtered rising edges -> EVCOUNT=0xF. Write EVCOUNT on the same edge as a rise -> reads 1.
- Mask=0x2; toggle 1->0 -> EDGECAP=0x2, irq=1. Assert reset mid-PEND_LO -> all registers 0, irq=0.

Source files
------------

// File: rtl/usb_gpx_pkg.sv
// Shared definitions for the GPX event controller.
//   - Avalon word addresses of the four registers
//   - bit positions of the rise/fall flags in IRQMASK and EDGECAP
//   - glitch-filter state encoding
package usb_gpx_pkg;

  localparam logic [1:0] STATUS  = 2'd0;
  localparam logic [1:0] IRQMASK = 2'd1;
  localparam logic [1:0] EDGECAP = 2'd2;
  localparam logic [1:0] EVCOUNT = 2'd3;

  localparam int RISE_BIT = 0;
  localparam int FALL_BIT = 1;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } filt_state_e;

  // STATUS word layout: bit0 filtered level, bit1 synchronized pin.
  function automatic logic [31:0] pack_status(input logic filtered, input logic sync_in);
    logic [31:0] r;
    r    = '0;
    r[0] = filtered;
    r[1] = sync_in;
    return r;
  endfunction

endpackage

// File: rtl/usb_gpx_filter.sv
// Input conditioning for the USB GPX pin.
// A SYNC_STAGES-deep synchronizer followed by a glitch filter that only
// accepts a new level after FILTER_CYCLES consecutive identical samples.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   in_port     : raw pin, asynchronous to clk
//   sync_in     : synchronized pin level
//   filtered    : debounced level
//   rise, fall  : one-cycle pulses when the debounced level changes
module usb_gpx_filter
  import usb_gpx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_port,
  output logic sync_in,
  output logic filtered,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] FC = 8'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;

  filt_state_e state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  cnt_inc;
  logic        filt_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // The counter holds the number of consecutive new-level samples already
  // taken, so a pend completes on the sample that brings it to FILTER_CYCLES.
  // That keeps the debounce latency at SYNC_STAGES + FILTER_CYCLES edges.
  assign cnt_inc = cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    filt_nxt  = filtered;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync_in) begin
          if (FC == 8'd1) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
            filt_nxt  = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = PEND_HI;
            cnt_nxt   = 8'd1;
          end
        end
      end
      PEND_HI: begin
        if (!sync_in) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt_inc == FC) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          filt_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      STABLE_HI: begin
        if (!sync_in) begin
          if (FC == 8'd1) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
            filt_nxt  = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = PEND_LO;
            cnt_nxt   = 8'd1;
          end
        end
      end
      PEND_LO: begin
        if (sync_in) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt_inc == FC) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          filt_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= STABLE_LO;
      cnt      <= '0;
      filtered <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      filtered <= filt_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
    end
  end

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// GPX pin event controller: Avalon-MM slave exposing the debounced USB
// GPX/interrupt pin to the Nios II as status, edge capture, interrupt
// mask and a saturating rising-edge counter.
// Ports:
//   clk, reset          : system clock, asynchronous active-high reset
//   address             : register word address (0 STATUS .. 3 EVCOUNT)
//   chipselect, write_n : write happens when chipselect=1 and write_n=0
//   writedata           : write data
//   readdata            : registered read data (one-cycle latency)
//   in_port             : raw GPX pin
//   irq                 : level interrupt, OR of masked edge-capture bits
module usb_gpx_event_ctrl
  import usb_gpx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  logic sync_in, filtered, rise, fall;

  logic [1:0]       irqmask, irqmask_nxt;
  logic [1:0]       edgecap, edgecap_nxt;
  logic [CNT_W-1:0] evcount, evcount_nxt;
  logic [31:0]      rd_nxt;

  logic       wr_en, wr_mask, wr_ecap, wr_cnt;
  logic [1:0] ecap_clr, ecap_set;
  logic       unused_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  usb_gpx_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync_in (sync_in),
    .filtered(filtered),
    .rise    (rise),
    .fall    (fall)
  );

  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en && (address == IRQMASK);
  assign wr_ecap = wr_en && (address == EDGECAP);
  assign wr_cnt  = wr_en && (address == EVCOUNT);

  // Only the low two bits are meaningful; EVCOUNT clears on any value.
  assign unused_wdata = ^writedata[31:2];

  always_comb begin
    ecap_clr           = wr_ecap ? writedata[1:0] : 2'b00;
    ecap_set           = 2'b00;
    ecap_set[RISE_BIT] = rise;
    ecap_set[FALL_BIT] = fall;
    // Set is applied after clear so a simultaneous event is never lost.
    edgecap_nxt        = (edgecap & ~ecap_clr) | ecap_set;

    irqmask_nxt = wr_mask ? writedata[1:0] : irqmask;

    // A clear coinciding with a rise counts that rise.
    if (wr_cnt)    evcount_nxt = rise ? CNT_W'(1) : '0;
    else if (rise) evcount_nxt = sat_inc(evcount);
    else           evcount_nxt = evcount;

    rd_nxt = '0;
    case (address)
      STATUS:  rd_nxt = pack_status(filtered, sync_in);
      IRQMASK: rd_nxt[1:0] = irqmask;
      EDGECAP: rd_nxt[1:0] = edgecap;
      EVCOUNT: rd_nxt = zext_cnt(evcount);
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask  <= '0;
      edgecap  <= '0;
      evcount  <= '0;
      readdata <= '0;
    end else begin
      irqmask  <= irqmask_nxt;
      edgecap  <= edgecap_nxt;
      evcount  <= evcount_nxt;
      readdata <= rd_nxt;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Self-checking bench for usb_gpx_event_ctrl (SYNC_STAGES=2,
// FILTER_CYCLES=4, CNT_W=4 so counter saturation is reachable quickly).
module tb_usb_gpx_event_ctrl;
  import usb_gpx_pkg::*;

  localparam int S       = 2;
  localparam int F       = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          q_sync[$];   // synchronizer delay line; element 0 is sync_in
  bit          q_hist[$];   // last F sync_in samples seen by the filter
  bit          m_filt, m_rise, m_fall;
  logic [1:0]  m_mask, m_ecap;
  int          m_cnt;
  logic [31:0] m_rdata;
  logic        m_irq;

  always #5 clk = ~clk;

  usb_gpx_event_ctrl #(
    .SYNC_STAGES  (S),
    .FILTER_CYCLES(F),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  task automatic model_reset();
    q_sync.delete();
    for (int i = 0; i < S; i++) q_sync.push_back(1'b0);
    q_hist.delete();
    m_filt = 0; m_rise = 0; m_fall = 0;
    m_mask = '0; m_ecap = '0; m_cnt = 0;
    m_rdata = '0; m_irq = 1'b0;
  endtask

  // One clock edge: the model consumes the inputs present before the edge.
  task automatic tick();
    bit          in_v, wr, old_sync, old_filt, old_rise, old_fall, all_new;
    logic [1:0]  a, old_mask, old_ecap;
    logic [31:0] wd;
    int          old_cnt;
    in_v = in_port; wr = chipselect && !write_n; a = address; wd = writedata;
    old_sync = q_sync[0]; old_filt = m_filt; old_rise = m_rise; old_fall = m_fall;
    old_mask = m_mask; old_ecap = m_ecap; old_cnt = m_cnt;
    @(posedge clk);
    case (a)
      2'd0:    m_rdata = {30'd0, old_sync, old_filt};
      2'd1:    m_rdata = {30'd0, old_mask};
      2'd2:    m_rdata = {30'd0, old_ecap};
      default: m_rdata = 32'(old_cnt);
    endcase
    if (wr && a == 2'd1) m_mask = wd[1:0];
    if (wr && a == 2'd2) m_ecap = old_ecap & ~wd[1:0];
    if (old_rise) m_ecap[0] = 1'b1;
    if (old_fall) m_ecap[1] = 1'b1;
    if (wr && a == 2'd3) m_cnt = old_rise ? 1 : 0;
    else if (old_rise && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    q_sync.push_back(in_v);
    void'(q_sync.pop_front());
    // Debounced level flips once the last F samples all disagree with it.
    q_hist.push_back(old_sync);
    if (q_hist.size() > F) void'(q_hist.pop_front());
    m_rise = 0; m_fall = 0;
    all_new = (q_hist.size() == F);
    foreach (q_hist[i]) if (q_hist[i] == m_filt) all_new = 0;
    if (all_new) begin
      m_filt = !m_filt;
      if (m_filt) m_rise = 1; else m_fall = 1;
    end
    m_irq = |(m_ecap & m_mask);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    chipselect = 1'b0; write_n = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    in_port = 1'b0;
    do_reset();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      checks++;
      if (readdata !== 32'd0) begin
        errors++; $display("FAIL reset_read[%0d]: got %h expected 0", a, readdata);
      end
    end
  endtask

  task automatic test_rise_default();
    int lat;
    lat = 0;
    in_port = 1'b1; address = STATUS;
    // Filtered level changes on edge S+F = 6; readdata shows it one edge later.
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (readdata[0] === 1'b1 && lat == 0) lat = i;
    end
    checks++;
    if (lat != S + F + 1) begin errors++; $display("FAIL rise_latency: got %0d expected %0d", lat, S + F + 1); end
    address = STATUS; tick();
    checks++;
    if (readdata !== 32'h3) begin errors++; $display("FAIL status_hi: got %h expected 3", readdata); end
    address = EDGECAP; tick();
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL edgecap_rise: got %h expected 1", readdata); end
    address = EVCOUNT; tick();
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL evcount_one: got %h expected 1", readdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
  endtask

  task automatic test_glitch_irq();
    in_port = 1'b0; ticks(10);
    bus_write(EDGECAP, 32'h3);
    bus_write(IRQMASK, 32'h1);
    in_port = 1'b1; ticks(3);
    in_port = 1'b0; ticks(10);
    address = EDGECAP; tick();
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL glitch_edgecap: got %h expected 0", readdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
    in_port = 1'b1; ticks(10);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b expected 1", irq); end
    bus_write(EDGECAP, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_set_wins();
    int n;
    in_port = 1'b0; ticks(10);
    bus_write(EDGECAP, 32'h3);
    in_port = 1'b1; n = 0;
    while (!m_rise && n < 30) begin tick(); n++; end
    checks++;
    if (n >= 30) begin errors++; $display("FAIL set_wins_timeout: got %0d cycles expected <30", n); end
    bus_write(EDGECAP, 32'h1);   // clear lands on the same edge as the set
    address = EDGECAP; tick();
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL set_wins: got %h expected 1", readdata); end
  endtask

  task automatic test_saturation();
    int n;
    bus_write(EVCOUNT, 32'h0);
    for (int i = 0; i < 20; i++) begin
      in_port = 1'b0; ticks(8);
      in_port = 1'b1; ticks(8);
    end
    address = EVCOUNT; tick();
    checks++;
    if (readdata !== 32'(CNT_MAX)) begin errors++; $display("FAIL evcount_sat: got %h expected %h", readdata, CNT_MAX); end
    in_port = 1'b0; ticks(8);
    in_port = 1'b1; n = 0;
    while (!m_rise && n < 30) begin tick(); n++; end
    bus_write(EVCOUNT, $urandom);
    address = EVCOUNT; tick();
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL evcount_clr_rise: got %h expected 1", readdata); end
    bus_write(EVCOUNT, 32'h0);
    address = EVCOUNT; tick();
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL evcount_clr: got %h expected 0", readdata); end
  endtask

  task automatic test_fall_reset();
    bus_write(IRQMASK, 32'h2);
    bus_write(EDGECAP, 32'h3);
    in_port = 1'b0; ticks(8);
    address = EDGECAP; tick();
    checks++;
    if (readdata !== 32'h2) begin errors++; $display("FAIL edgecap_fall: got %h expected 2", readdata); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL fall_irq: got %b expected 1", irq); end
    in_port = 1'b1; ticks(8);
    in_port = 1'b0; ticks(4);    // filter is now part way through PEND_LO
    do_reset();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a); tick();
      checks++;
      if (readdata !== 32'd0) begin errors++; $display("FAIL midreset_read[%0d]: got %h expected 0", a, readdata); end
    end
    ticks(8);
    address = EDGECAP; tick();
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL pend_discarded: got %h expected 0", readdata); end
    in_port = 1'b1;
    do_reset();
    ticks(10);
    address = EDGECAP; tick();
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL rise_after_reset: got %h expected 1", readdata); end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        in_port = $urandom_range(0, 1);
        hold = $urandom_range(1, 9);
      end
      hold--;
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom;
      tick();
      checks++;
      if (readdata !== m_rdata) begin
        errors++; $display("FAIL rand_readdata @%0d: got %h expected %h", i, readdata, m_rdata);
      end
      checks++;
      if (irq !== m_irq) begin
        errors++; $display("FAIL rand_irq @%0d: got %b expected %b", i, irq, m_irq);
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_rise_default();
    test_glitch_irq();
    test_set_wins();
    test_saturation();
    test_fall_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
